video_mixer_gen: RTL and testbench
==================================

// Module: video_mixer_gen
// PURPOSE
//  Parametrised successor video output stage: expands DW-bit RGB to 8 bits, optional runtime gamma LUT,
//  registered sync/DE generation, per-line active-pixel clip, frame-aligned freeze engine.
//  Sits between core video (RGB/sync/blank, ce_pix) and the VGA/HDMI scaler front end.
// PARAMETERS
//  DW           8    input bits per colour channel, 1..8
//  GAMMA        1    1: instantiate 3x256x8 gamma LUT; 0: LUT logic absent, gamma_en ignored
//  LINE_LENGTH  768  max active pixels per line; pixels beyond are blanked (DE=0, RGB=0)
// PORTS
//  CLK_VIDEO      in   1   video clock, all logic on rising edge
//  reset          in   1   asynchronous, active-high
//  ce_pix         in   1   input pixel clock enable
//  R,G,B          in   DW  input colour
//  HSync,VSync    in   1   positive sync pulses
//  HBlank,VBlank  in   1   positive blanking
//  gamma_en       in   1   request gamma correction (sampled per frame)
//  gamma_wr       in   1   LUT write strobe, one entry per cycle
//  gamma_wr_addr  in   10  [9:8] channel 0=R 1=G 2=B 3=ignored; [7:0] index
//  gamma_value    in   8   LUT write data
//  HDMI_FREEZE    in   1   freeze request (level)
//  freeze_sync    out  1   high while output is frozen
//  CE_PIXEL       out  1   output pixel enable
//  VGA_R,G,B      out  8   output colour
//  VGA_HS,VGA_VS  out  1   output syncs
//  VGA_DE         out  1   output data enable
// BEHAVIOUR
//  Reset: all outputs 0; FSM=RUN; gamma_act=0; line counter=0. LUT contents not reset.
//  Depth expansion: bit replication of input MSB-first, truncated to 8 (DW=3: 101 -> 10110110).
//  Pipeline advances only on ce_pix: S1 expand+sync/blank register, S2 LUT read (or matching delay reg),
//   S3 output register. Latency = 3 ce_pix. CE_PIXEL = ce_pix delayed one CLK_VIDEO (high the cycle
//   after outputs update). Syncs/blanks delayed identically to colour; no skew between them.
//  VGA_DE = ~(HBlank|VBlank) & ~clip & ~FROZEN. RGB forced 0 whenever VGA_DE=0.
//  Clip: 10-bit-min counter of active pixels, cleared at HBlank; saturates at LINE_LENGTH; pixel index
//   >= LINE_LENGTH -> clip=1.
//  Gamma: gamma_act latched from gamma_en at each VSync rising edge (on ce_pix); never changes mid-frame.
//   LUT write-any-time, synchronous read, read-first on same-address collision; channel 3 writes dropped.
//  Freeze FSM (transitions evaluated on ce_pix, vs_rise = VSync rising at S1):
//   RUN        -> ARM_FRZ on HDMI_FREEZE=1
//   ARM_FRZ    -> FROZEN on vs_rise & HDMI_FREEZE; -> RUN if HDMI_FREEZE drops first
//   FROZEN     -> ARM_RUN on HDMI_FREEZE=0
//   ARM_RUN    -> RUN on vs_rise & !HDMI_FREEZE; -> FROZEN if HDMI_FREEZE reasserts
//   Simultaneous vs_rise and HDMI_FREEZE change: HDMI_FREEZE value of that cycle wins.
//   freeze_sync=1 in FROZEN and ARM_RUN. HS/VS keep toggling in all states.
//  Reset mid-frame: immediate return to reset values; state resumes from RUN, gamma_act=0 until next vs_rise.
//  ce_pix stuck low: outputs hold, CE_PIXEL=0.
// STRUCTURE
//  video_mixer_pkg: freeze_state_t enum (RUN,ARM_FRZ,FROZEN,ARM_RUN), GAMMA_CH_R/G/B/NONE
//   constants, function expand_depth(in,DW).
//  Sub-module gamma_lut_ram: 3x256x8 simple dual-port, read-first, one write port, three read ports;
//   generated only when GAMMA=1.
// TESTING
//  DW=3, R=3'b101 G=0 B=7, no blanking -> after 3 ce_pix VGA_R=8'hB6 G=00 B=FF, DE=1.
//  Load LUT R[i]=255-i, gamma_en=1 mid-frame, R=8'h10 -> output 10 until next VSync rise, then EF.
//  LINE_LENGTH=4, 6 active pixels/line -> DE high 4 ce_pix, low 2, RGB=0 for pixels 5-6.
//  HDMI_FREEZE=1 mid-frame -> DE continues until next VSync rise, then DE=0, RGB=0, HS/VS toggling,
//   freeze_sync=1; drop HDMI_FREEZE -> DE resumes exactly at following VSync rise.
//  HDMI_FREEZE pulse released before VSync -> FSM returns to RUN, freeze_sync never asserts.
//  Assert reset while FROZEN with gamma active -> all outputs 0 same cycle; after release FSM RUN, passthrough.

Source files
------------

// File: rtl/video_mixer_pkg.sv
// Shared types, LUT channel codes and colour-depth expansion for the video mixer output stage.
package video_mixer_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ARM_FRZ = 2'd1,
    FROZEN  = 2'd2,
    ARM_RUN = 2'd3
  } freeze_state_t;

  localparam logic [1:0] GAMMA_CH_R    = 2'd0;
  localparam logic [1:0] GAMMA_CH_G    = 2'd1;
  localparam logic [1:0] GAMMA_CH_B    = 2'd2;
  localparam logic [1:0] GAMMA_CH_NONE = 2'd3;

  // Input occupies val[dw-1:0]; its bits are repeated MSB-first to fill 8 bits.
  function automatic logic [7:0] expand_depth(input logic [7:0] val, input int dw);
    logic [7:0] res;
    logic [2:0] src;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      src = 3'(dw - 1 - (k % dw));
      res[3'(7 - k)] = val[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/video_mixer_gen_gamma_lut_ram.sv
// Three 256x8 gamma tables sharing one write port, each with its own synchronous read port.
module gamma_lut_ram
  import video_mixer_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [1:0] wr_ch_i,
  input  logic [7:0] wr_idx_i,
  input  logic [7:0] wr_data_i,
  input  logic       re_i,
  input  logic [7:0] rd_r_idx_i,
  input  logic [7:0] rd_g_idx_i,
  input  logic [7:0] rd_b_idx_i,
  output logic [7:0] rd_r_o,
  output logic [7:0] rd_g_o,
  output logic [7:0] rd_b_o
);

  logic [7:0] mem_r [256];
  logic [7:0] mem_g [256];
  logic [7:0] mem_b [256];
  logic [7:0] rd_r_q, rd_g_q, rd_b_q;

  // Non-blocking read and write in one block gives old data on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (we_i && (wr_ch_i == GAMMA_CH_R)) mem_r[wr_idx_i] <= wr_data_i;
    if (we_i && (wr_ch_i == GAMMA_CH_G)) mem_g[wr_idx_i] <= wr_data_i;
    if (we_i && (wr_ch_i == GAMMA_CH_B)) mem_b[wr_idx_i] <= wr_data_i;
    if (re_i) begin
      rd_r_q <= mem_r[rd_r_idx_i];
      rd_g_q <= mem_g[rd_g_idx_i];
      rd_b_q <= mem_b[rd_b_idx_i];
    end
  end

  assign rd_r_o = rd_r_q;
  assign rd_g_o = rd_g_q;
  assign rd_b_o = rd_b_q;

endmodule

// File: rtl/video_mixer_gen.sv
// Video output stage: depth expansion, optional gamma LUT, line clip and frame-aligned freeze.
// Three ce_pix stages: S1 expand/sync capture, S2 LUT read or matching delay, S3 output register.
module video_mixer_gen #(
  parameter int DW          = 8,
  parameter int GAMMA       = 1,
  parameter int LINE_LENGTH = 768
) (
  input  logic          CLK_VIDEO,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [DW-1:0] R,
  input  logic [DW-1:0] G,
  input  logic [DW-1:0] B,
  input  logic          HSync,
  input  logic          VSync,
  input  logic          HBlank,
  input  logic          VBlank,
  input  logic          gamma_en,
  input  logic          gamma_wr,
  input  logic [9:0]    gamma_wr_addr,
  input  logic [7:0]    gamma_value,
  input  logic          HDMI_FREEZE,
  output logic          freeze_sync,
  output logic          CE_PIXEL,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE
);
  import video_mixer_pkg::*;

  localparam int CW = ($clog2(LINE_LENGTH + 1) > 10) ? $clog2(LINE_LENGTH + 1) : 10;
  localparam logic [CW-1:0] LINE_MAX = CW'(LINE_LENGTH);

  logic [7:0]    r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
  logic          hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q, gam2_q;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic          gamma_act_q;
  freeze_state_t state_q;
  logic          freeze_sync_q;
  logic [7:0]    lut_r, lut_g, lut_b;
  logic [7:0]    vga_r_q, vga_g_q, vga_b_q;
  logic          vga_hs_q, vga_vs_q, vga_de_q, ce_q;
  logic          blank;
  logic          vs_rise;

  assign blank   = HBlank | VBlank;
  assign vs_rise = VSync & ~vs1_q;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (blank) pix_cnt_d = '0;
    else if (pix_cnt_q != LINE_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
  end

  // S1: gamma_act_q and freeze_sync_q are also loaded here, so both stay aligned with the S1 pixel.
  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      r1_q        <= '0;
      g1_q        <= '0;
      b1_q        <= '0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      de1_q       <= 1'b0;
      pix_cnt_q   <= '0;
      gamma_act_q <= 1'b0;
    end else if (ce_pix) begin
      r1_q      <= expand_depth(8'(R), DW);
      g1_q      <= expand_depth(8'(G), DW);
      b1_q      <= expand_depth(8'(B), DW);
      hs1_q     <= HSync;
      vs1_q     <= VSync;
      de1_q     <= ~blank & (pix_cnt_q < LINE_MAX);
      pix_cnt_q <= pix_cnt_d;
      if (vs_rise) gamma_act_q <= gamma_en & (GAMMA != 0);
    end
  end

  // state   | meaning
  // RUN     | normal output
  // ARM_FRZ | freeze requested, waiting for next VSync rise
  // FROZEN  | output blanked, syncs still running
  // ARM_RUN | release requested, still blanked until next VSync rise
  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      freeze_sync_q <= 1'b0;
    end else if (ce_pix) begin
      case (state_q)
        RUN: if (HDMI_FREEZE) state_q <= ARM_FRZ;
        ARM_FRZ: begin
          if (!HDMI_FREEZE) state_q <= RUN;
          else if (vs_rise) begin
            state_q       <= FROZEN;
            freeze_sync_q <= 1'b1;
          end
        end
        FROZEN: if (!HDMI_FREEZE) state_q <= ARM_RUN;
        ARM_RUN: begin
          if (HDMI_FREEZE) state_q <= FROZEN;
          else if (vs_rise) begin
            state_q       <= RUN;
            freeze_sync_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= RUN;
          freeze_sync_q <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (GAMMA != 0) begin : g_lut
      gamma_lut_ram u_lut (
        .clk_i      (CLK_VIDEO),
        .we_i       (gamma_wr),
        .wr_ch_i    (gamma_wr_addr[9:8]),
        .wr_idx_i   (gamma_wr_addr[7:0]),
        .wr_data_i  (gamma_value),
        .re_i       (ce_pix),
        .rd_r_idx_i (r1_q),
        .rd_g_idx_i (g1_q),
        .rd_b_idx_i (b1_q),
        .rd_r_o     (lut_r),
        .rd_g_o     (lut_g),
        .rd_b_o     (lut_b)
      );
    end else begin : g_nolut
      assign lut_r = '0;
      assign lut_g = '0;
      assign lut_b = '0;
    end
  endgenerate

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      r2_q     <= '0;
      g2_q     <= '0;
      b2_q     <= '0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      de2_q    <= 1'b0;
      gam2_q   <= 1'b0;
      vga_r_q  <= '0;
      vga_g_q  <= '0;
      vga_b_q  <= '0;
      vga_hs_q <= 1'b0;
      vga_vs_q <= 1'b0;
      vga_de_q <= 1'b0;
    end else if (ce_pix) begin
      r2_q     <= r1_q;
      g2_q     <= g1_q;
      b2_q     <= b1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      de2_q    <= de1_q & ~freeze_sync_q;
      gam2_q   <= gamma_act_q;
      vga_hs_q <= hs2_q;
      vga_vs_q <= vs2_q;
      vga_de_q <= de2_q;
      vga_r_q  <= de2_q ? (gam2_q ? lut_r : r2_q) : 8'h00;
      vga_g_q  <= de2_q ? (gam2_q ? lut_g : g2_q) : 8'h00;
      vga_b_q  <= de2_q ? (gam2_q ? lut_b : b2_q) : 8'h00;
    end
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) ce_q <= 1'b0;
    else       ce_q <= ce_pix;
  end

  assign freeze_sync = freeze_sync_q;
  assign CE_PIXEL    = ce_q;
  assign VGA_R       = vga_r_q;
  assign VGA_G       = vga_g_q;
  assign VGA_B       = vga_b_q;
  assign VGA_HS      = vga_hs_q;
  assign VGA_VS      = vga_vs_q;
  assign VGA_DE      = vga_de_q;

endmodule

// File: tb/tb_video_mixer_gen.sv
// Directed bench: a DW=3/no-gamma instance for depth expansion, a DW=8/gamma/LINE_LENGTH=4 instance for the rest.
module tb_video_mixer_gen;

  logic       clk = 1'b0;
  logic       rst, ce, hs, vs, hb, vb, gen, gwr, frz;
  logic [2:0] r3, g3, b3;
  logic [7:0] r8, g8, b8, gval;
  logic [9:0] gaddr;

  logic [7:0] o3_r, o3_g, o3_b, o8_r, o8_g, o8_b;
  logic       o3_hs, o3_vs, o3_de, o3_ce, o3_fz;
  logic       o8_hs, o8_vs, o8_de, o8_ce, o8_fz;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  video_mixer_gen #(.DW(3), .GAMMA(0), .LINE_LENGTH(768)) dut3 (
    .CLK_VIDEO(clk), .reset(rst), .ce_pix(ce), .R(r3), .G(g3), .B(b3),
    .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb), .gamma_en(gen),
    .gamma_wr(gwr), .gamma_wr_addr(gaddr), .gamma_value(gval), .HDMI_FREEZE(frz),
    .freeze_sync(o3_fz), .CE_PIXEL(o3_ce), .VGA_R(o3_r), .VGA_G(o3_g), .VGA_B(o3_b),
    .VGA_HS(o3_hs), .VGA_VS(o3_vs), .VGA_DE(o3_de));

  video_mixer_gen #(.DW(8), .GAMMA(1), .LINE_LENGTH(4)) dut8 (
    .CLK_VIDEO(clk), .reset(rst), .ce_pix(ce), .R(r8), .G(g8), .B(b8),
    .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb), .gamma_en(gen),
    .gamma_wr(gwr), .gamma_wr_addr(gaddr), .gamma_value(gval), .HDMI_FREEZE(frz),
    .freeze_sync(o8_fz), .CE_PIXEL(o8_ce), .VGA_R(o8_r), .VGA_G(o8_g), .VGA_B(o8_b),
    .VGA_HS(o8_hs), .VGA_VS(o8_vs), .VGA_DE(o8_de));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic h, input logic v, input logic hbk, input logic vbk);
    hs = h; vs = v; hb = hbk; vb = vbk; ce = 1'b1;
    tick();
  endtask

  task automatic idle();
    ce = 1'b0;
    tick();
  endtask

  // After this, the outputs show the line's first active pixel.
  task automatic line();
    pix(0, 0, 1, 0);
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);
  endtask

  task automatic vpulse();
    pix(0, 1, 0, 1);
    pix(0, 1, 0, 1);
    pix(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; hs = 0; vs = 0; hb = 0; vb = 0; gen = 0; gwr = 0; frz = 0;
    r3 = '0; g3 = '0; b3 = '0; r8 = '0; g8 = '0; b8 = '0; gval = '0; gaddr = '0;
    repeat (3) tick();
    n_cmp++; if (o8_r !== 8'h00) begin n_bad++; $display("FAIL reset_r got=%h exp=00", o8_r); end
    n_cmp++; if (o8_g !== 8'h00) begin n_bad++; $display("FAIL reset_g got=%h exp=00", o8_g); end
    n_cmp++; if (o8_b !== 8'h00) begin n_bad++; $display("FAIL reset_b got=%h exp=00", o8_b); end
    n_cmp++; if (o8_de !== 1'b0) begin n_bad++; $display("FAIL reset_de got=%b exp=0", o8_de); end
    n_cmp++; if ({o8_hs, o8_vs} !== 2'b00) begin n_bad++; $display("FAIL reset_sync got=%b exp=00", {o8_hs, o8_vs}); end
    n_cmp++; if (o8_ce !== 1'b0) begin n_bad++; $display("FAIL reset_ce got=%b exp=0", o8_ce); end
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL reset_fz got=%b exp=0", o8_fz); end
    n_cmp++;
    if ({o3_r, o3_g, o3_b, o3_hs, o3_vs, o3_de, o3_ce, o3_fz} !== 29'd0) begin
      n_bad++; $display("FAIL reset_dut3 got=%h exp=0", {o3_r, o3_g, o3_b, o3_hs, o3_vs, o3_de, o3_ce, o3_fz});
    end
    rst = 1'b0;
  endtask

  task automatic test_expand();
    r3 = 3'b101; g3 = 3'b000; b3 = 3'b111;
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);
    n_cmp++; if (o3_r !== 8'h00) begin n_bad++; $display("FAIL latency_r got=%h exp=00", o3_r); end
    pix(0, 0, 0, 0);
    n_cmp++; if (o3_r !== 8'hB6) begin n_bad++; $display("FAIL expand_r got=%h exp=B6", o3_r); end
    n_cmp++; if (o3_g !== 8'h00) begin n_bad++; $display("FAIL expand_g got=%h exp=00", o3_g); end
    n_cmp++; if (o3_b !== 8'hFF) begin n_bad++; $display("FAIL expand_b got=%h exp=FF", o3_b); end
    n_cmp++; if (o3_de !== 1'b1) begin n_bad++; $display("FAIL expand_de got=%b exp=1", o3_de); end
    n_cmp++; if (o3_ce !== 1'b1) begin n_bad++; $display("FAIL expand_ce got=%b exp=1", o3_ce); end
    r3 = 3'b011; g3 = 3'b001; b3 = 3'b100;
    repeat (3) pix(0, 0, 0, 0);
    n_cmp++; if (o3_r !== 8'h6D) begin n_bad++; $display("FAIL expand2_r got=%h exp=6D", o3_r); end
    n_cmp++; if (o3_g !== 8'h24) begin n_bad++; $display("FAIL expand2_g got=%h exp=24", o3_g); end
    n_cmp++; if (o3_b !== 8'h92) begin n_bad++; $display("FAIL expand2_b got=%h exp=92", o3_b); end
    r3 = 3'b000;
    repeat (3) idle();
    n_cmp++; if (o3_r !== 8'h6D) begin n_bad++; $display("FAIL cestuck_hold got=%h exp=6D", o3_r); end
    n_cmp++; if (o3_ce !== 1'b0) begin n_bad++; $display("FAIL cestuck_ce got=%b exp=0", o3_ce); end
  endtask

  task automatic test_clip();
    logic       hb_t [12];
    logic [7:0] r_t  [12];
    logic       de_t [12];
    logic [7:0] er_t [12];
    hb_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    r_t  = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h77, 8'h21, 8'h22, 8'h66, 8'h66};
    de_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    er_t = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h21, 8'h22, 8'h00, 8'h00};
    g8 = 8'h00; b8 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      r8 = r_t[i];
      pix(0, 0, hb_t[i], 0);
      if (i >= 2) begin
        n_cmp++;
        if (o8_de !== de_t[i-2]) begin n_bad++; $display("FAIL clip_de[%0d] got=%b exp=%b", i-2, o8_de, de_t[i-2]); end
        n_cmp++;
        if (o8_r !== er_t[i-2]) begin n_bad++; $display("FAIL clip_r[%0d] got=%h exp=%h", i-2, o8_r, er_t[i-2]); end
      end
    end
  endtask

  task automatic test_gamma();
    gwr = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < 256; i++) begin
        gaddr = {ch[1:0], i[7:0]};
        gval  = (ch == 1) ? i[7:0] : 8'(255 - i);
        idle();
      end
    end
    gaddr = 10'h310; gval = 8'h00;
    idle();
    gwr = 1'b0;
    n_cmp++; if (o8_ce !== 1'b0) begin n_bad++; $display("FAIL load_ce got=%b exp=0", o8_ce); end
    n_cmp++; if (o8_r !== 8'h22) begin n_bad++; $display("FAIL load_hold got=%h exp=22", o8_r); end
    gen = 1'b1; r8 = 8'h10; g8 = 8'h20; b8 = 8'h30;
    line();
    n_cmp++; if (o8_r !== 8'h10) begin n_bad++; $display("FAIL gamma_midframe got=%h exp=10", o8_r); end
    vpulse();
    line();
    n_cmp++; if (o8_r !== 8'hEF) begin n_bad++; $display("FAIL gamma_r got=%h exp=EF", o8_r); end
    n_cmp++; if (o8_g !== 8'h20) begin n_bad++; $display("FAIL gamma_g got=%h exp=20", o8_g); end
    n_cmp++; if (o8_b !== 8'hCF) begin n_bad++; $display("FAIL gamma_b got=%h exp=CF", o8_b); end
    gen = 1'b0;
    line();
    n_cmp++; if (o8_r !== 8'hEF) begin n_bad++; $display("FAIL gamma_hold got=%h exp=EF", o8_r); end
    vpulse();
    line();
    n_cmp++; if (o8_r !== 8'h10) begin n_bad++; $display("FAIL gamma_off got=%h exp=10", o8_r); end
    gen = 1'b1;
    vpulse();
    line();
    n_cmp++; if (o8_r !== 8'hEF) begin n_bad++; $display("FAIL gamma_on2 got=%h exp=EF", o8_r); end
  endtask

  task automatic test_freeze();
    frz = 1'b1;
    line();
    n_cmp++; if (o8_de !== 1'b1) begin n_bad++; $display("FAIL arm_de got=%b exp=1", o8_de); end
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL arm_fz got=%b exp=0", o8_fz); end
    pix(0, 0, 1, 0);
    pix(0, 0, 0, 0);
    pix(0, 1, 0, 0);
    n_cmp++; if (o8_fz !== 1'b1) begin n_bad++; $display("FAIL frz_fz got=%b exp=1", o8_fz); end
    pix(0, 1, 0, 0);
    n_cmp++; if (o8_de !== 1'b1) begin n_bad++; $display("FAIL frz_pre_de got=%b exp=1", o8_de); end
    n_cmp++; if (o8_r !== 8'hEF) begin n_bad++; $display("FAIL frz_pre_r got=%h exp=EF", o8_r); end
    pix(0, 0, 0, 0);
    n_cmp++; if (o8_de !== 1'b0) begin n_bad++; $display("FAIL frz_edge_de got=%b exp=0", o8_de); end
    n_cmp++; if (o8_r !== 8'h00) begin n_bad++; $display("FAIL frz_edge_r got=%h exp=00", o8_r); end
    n_cmp++; if (o8_vs !== 1'b1) begin n_bad++; $display("FAIL frz_vs got=%b exp=1", o8_vs); end
    pix(1, 0, 1, 0);
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);
    n_cmp++; if (o8_hs !== 1'b1) begin n_bad++; $display("FAIL frz_hs_hi got=%b exp=1", o8_hs); end
    pix(0, 0, 0, 0);
    n_cmp++; if ({o8_hs, o8_de} !== 2'b00) begin n_bad++; $display("FAIL frz_hs_lo got=%b exp=00", {o8_hs, o8_de}); end
    frz = 1'b0;
    line();
    n_cmp++; if (o8_de !== 1'b0) begin n_bad++; $display("FAIL armrun_de got=%b exp=0", o8_de); end
    n_cmp++; if (o8_fz !== 1'b1) begin n_bad++; $display("FAIL armrun_fz got=%b exp=1", o8_fz); end
    pix(0, 0, 1, 0);
    pix(0, 0, 0, 0);
    pix(0, 1, 0, 0);
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL resume_fz got=%b exp=0", o8_fz); end
    pix(0, 1, 0, 0);
    n_cmp++; if (o8_de !== 1'b0) begin n_bad++; $display("FAIL resume_pre_de got=%b exp=0", o8_de); end
    pix(0, 0, 0, 0);
    n_cmp++; if (o8_de !== 1'b1) begin n_bad++; $display("FAIL resume_de got=%b exp=1", o8_de); end
    n_cmp++; if (o8_r !== 8'hEF) begin n_bad++; $display("FAIL resume_r got=%h exp=EF", o8_r); end
  endtask

  task automatic test_pulse();
    frz = 1'b1;
    pix(0, 0, 1, 0);
    pix(0, 0, 0, 0);
    frz = 1'b0;
    pix(0, 0, 0, 0);
    vpulse();
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL pulse_fz got=%b exp=0", o8_fz); end
    line();
    n_cmp++; if (o8_de !== 1'b1) begin n_bad++; $display("FAIL pulse_de got=%b exp=1", o8_de); end
    frz = 1'b1;
    line();
    frz = 1'b0;
    pix(0, 1, 0, 1);
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL simul_fz got=%b exp=0", o8_fz); end
    pix(0, 1, 0, 1);
    pix(0, 0, 0, 1);
    line();
    n_cmp++; if (o8_de !== 1'b1) begin n_bad++; $display("FAIL simul_de got=%b exp=1", o8_de); end
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL simul_fz2 got=%b exp=0", o8_fz); end
  endtask

  task automatic test_reset_frozen();
    frz = 1'b1;
    line();
    vpulse();
    line();
    n_cmp++; if (o8_fz !== 1'b1) begin n_bad++; $display("FAIL rf_frozen got=%b exp=1", o8_fz); end
    pix(1, 0, 1, 0);
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);
    n_cmp++; if (o8_hs !== 1'b1) begin n_bad++; $display("FAIL rf_hs got=%b exp=1", o8_hs); end
    rst = 1'b1;
    #2;
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL rf_fz got=%b exp=0", o8_fz); end
    n_cmp++;
    if ({o8_r, o8_g, o8_b, o8_hs, o8_vs, o8_de, o8_ce} !== 28'd0) begin
      n_bad++; $display("FAIL rf_outs got=%h exp=0", {o8_r, o8_g, o8_b, o8_hs, o8_vs, o8_de, o8_ce});
    end
    frz = 1'b0;
    tick();
    rst = 1'b0;
    line();
    n_cmp++; if (o8_de !== 1'b1) begin n_bad++; $display("FAIL rf_after_de got=%b exp=1", o8_de); end
    n_cmp++; if (o8_r !== 8'h10) begin n_bad++; $display("FAIL rf_after_r got=%h exp=10", o8_r); end
    n_cmp++; if (o8_fz !== 1'b0) begin n_bad++; $display("FAIL rf_after_fz got=%b exp=0", o8_fz); end
  endtask

  initial begin
    test_reset();
    test_expand();
    test_clip();
    test_gamma();
    test_freeze();
    test_pulse();
    test_reset_frozen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
